bagman_rom_loader: RTL and testbench
====================================

BAGMAN_ROM_LOADER -- requirements
Module: bagman_rom_loader

Interface
REQ-001 SHALL have parameter ROM_BYTES, default 65536, meaning the number of bytes accepted into the core ROM space (at most 131072).
REQ-002 SHALL have parameter HOLD_CYCLES, default 16, meaning the clk_sys cycles core_reset stays high after a download ends (at least 1).
REQ-003 SHALL have parameter EXPECTED_SUM, default 16'h0000, meaning the reference checksum, used only when the checksum feature is compiled in.
REQ-004 SHALL have port clk_sys, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port ioctl_download, input, 1 bit: high while the HPS streams ROM data.
REQ-007 SHALL have port ioctl_wr, input, 1 bit: one-cycle strobe qualifying ioctl_addr and ioctl_dout.
REQ-008 SHALL have port ioctl_addr, input, 25 bits: byte address of the current write.
REQ-009 SHALL have port ioctl_dout, input, 8 bits: byte data of the current write.
REQ-010 SHALL have port dn_addr, output, 17 bits: registered ROM write address to the core.
REQ-011 SHALL have port dn_data, output, 8 bits: registered ROM write data to the core.
REQ-012 SHALL have port dn_wr, output, 1 bit: registered one-cycle ROM write strobe to the core.
REQ-013 SHALL have port core_reset, output, 1 bit: active-high core reset.
REQ-014 SHALL have port rom_ok, output, 1 bit: the last completed download was complete and valid.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag; a write at or above ROM_BYTES was dropped in the current download.
REQ-016 SHALL have port rom_sum, output, 16 bits: running modulo-2^16 byte checksum.

Function
REQ-017 SHALL implement the states IDLE, LOAD, HOLD and RUN.
REQ-018 SHALL move from IDLE or RUN to LOAD on the first cycle ioctl_download is high.
- On entry: clear the byte counter, overrun, rom_sum and rom_ok.
REQ-019 SHALL, in LOAD, forward each write with ioctl_wr=1 and ioctl_addr<ROM_BYTES to dn_addr/dn_data/dn_wr, registered with exactly 1 cycle latency, and increment a 17-bit byte counter.
REQ-020 SHALL drop writes with ioctl_addr>=ROM_BYTES: no dn_wr, no count; overrun set on the next cycle.
REQ-021 SHALL keep dn_wr low outside LOAD and hold dn_addr/dn_data at their last values.
REQ-022 SHALL move from LOAD to HOLD on the first cycle ioctl_download is low.
- A write strobed on that same cycle is still accepted and forwarded.
REQ-023 SHALL, in HOLD, count HOLD_CYCLES cycles, then enter RUN.
- In RUN, core_reset=0 and rom_ok=(byte count==ROM_BYTES) and overrun==0.
REQ-024 SHALL hold core_reset=1 in IDLE, LOAD and HOLD.
REQ-025 SHALL, if ioctl_download rises during HOLD, abandon the hold and enter LOAD on the next cycle.
REQ-026 SHALL, on a new download in RUN, assert core_reset in the cycle after ioctl_download rises.
REQ-027 SHALL saturate the byte counter at ROM_BYTES; duplicate addresses still count.

Reset
REQ-028 SHALL, while reset_n=0, force state IDLE and all counters to 0, with outputs as follows.
- dn_addr=0, dn_data=0, dn_wr=0.
- core_reset=1, rom_ok=0, overrun=0, rom_sum=0.
REQ-029 SHALL abort any download in progress when reset_n is asserted, and remain in IDLE until ioctl_download is next seen high.

Configuration
REQ-030 SHALL, with BAGMAN_ROM_CHECKSUM_EN defined, add each accepted byte to rom_sum and additionally require rom_sum==EXPECTED_SUM for rom_ok.
REQ-031 SHALL, without BAGMAN_ROM_CHECKSUM_EN, tie rom_sum to 0, exclude the checksum from rom_ok, and contain no adder logic.

Verification
REQ-032 Stream ROM_BYTES=16, bytes 0x01..0x10 at addresses 0..15, then drop download -> 16 dn_wr pulses, each 1 cycle after its ioctl_wr; core_reset falls 16 cycles after HOLD entry; rom_ok=1.
REQ-033 Stream 16 bytes plus 1 write at address 16 -> no dn_wr for address 16; overrun=1; rom_ok=0; core_reset still released.
REQ-034 Stream only 12 bytes -> rom_ok=0 in RUN; core_reset released.
REQ-035 Pulse reset_n low mid-LOAD at byte 8 -> all outputs take reset values immediately; IDLE; core_reset stays 1 with no further download.
REQ-036 Re-raise ioctl_download 5 cycles into HOLD, and separately during RUN -> LOAD re-entered, core_reset=1 next cycle, counters cleared.
REQ-037 With BAGMAN_ROM_CHECKSUM_EN and EXPECTED_SUM=16'h0088 on the 0x01..0x10 stream -> rom_sum=0x0088, rom_ok=1; repeat with one byte altered -> rom_ok=0.

Source files
------------

// File: rtl/bagman_rom_loader.sv
// Streams HPS ROM bytes into the core and holds the core in reset until the image is in place.
// Optional checksum adder and check: define BAGMAN_ROM_CHECKSUM_EN.
module bagman_rom_loader #(
  parameter int          ROM_BYTES    = 65536,
  parameter int          HOLD_CYCLES  = 16,
  parameter logic [15:0] EXPECTED_SUM = 16'h0000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic        core_reset,
  output logic        rom_ok,
  output logic        overrun,
  output logic [15:0] rom_sum
);

  localparam int CW = $clog2(ROM_BYTES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [24:0]   ADDR_LIM  = 25'(ROM_BYTES);
  localparam logic [CW-1:0] CNT_MAX   = CW'(ROM_BYTES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] byte_cnt;
  logic [HW-1:0] hold_cnt;
  logic          wr_in;
  logic          accept;
  logic          drop;
  logic          start;
  logic          sum_ok;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, RUN: if (ioctl_download) state_nx = LOAD;
      LOAD:      if (!ioctl_download) state_nx = HOLD;
      HOLD: begin
        if (ioctl_download)             state_nx = LOAD;
        else if (hold_cnt == HOLD_LAST) state_nx = RUN;
      end
      default:   state_nx = IDLE;
    endcase
  end

  assign wr_in      = (state == LOAD) && ioctl_wr;
  assign accept     = wr_in && (ioctl_addr < ADDR_LIM);
  assign drop       = wr_in && !accept;
  assign start      = (state_nx == LOAD) && (state != LOAD);
  assign core_reset = (state != RUN);

`ifdef BAGMAN_ROM_CHECKSUM_EN
  logic [15:0] sum_q;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else if (start) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= sum_q + {8'h00, ioctl_dout};
    end
  end

  assign rom_sum = sum_q;
  assign sum_ok  = (sum_q == EXPECTED_SUM);
`else
  // Reference sum is ignored; the term folds to a constant 1.
  assign rom_sum = '0;
  assign sum_ok  = 1'b1 | (^EXPECTED_SUM);
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      hold_cnt <= '0;
      dn_addr  <= '0;
      dn_data  <= '0;
      dn_wr    <= 1'b0;
      overrun  <= 1'b0;
      rom_ok   <= 1'b0;
    end else begin
      state    <= state_nx;
      dn_wr    <= accept;
      hold_cnt <= (state == HOLD) ? hold_cnt + HW'(1) : '0;
      if (accept) begin
        dn_addr <= ioctl_addr[16:0];
        dn_data <= ioctl_dout;
      end
      if (start) begin
        byte_cnt <= '0;
        overrun  <= 1'b0;
        rom_ok   <= 1'b0;
      end else begin
        if (accept && (byte_cnt != CNT_MAX)) byte_cnt <= byte_cnt + CW'(1);
        if (drop) overrun <= 1'b1;
        if ((state == HOLD) && (state_nx == RUN))
          rom_ok <= (byte_cnt == CNT_MAX) && !overrun && sum_ok;
      end
    end
  end

endmodule

// File: tb/tb_bagman_rom_loader.sv
// Scoreboard bench for bagman_rom_loader with a 16-byte ROM and 16-cycle hold.
// Checksum expectations follow BAGMAN_ROM_CHECKSUM_EN.
module tb_bagman_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic        core_reset;
  logic        rom_ok;
  logic        overrun;
  logic [15:0] rom_sum;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
    int          c;
  } exp_t;

  exp_t sbq[$];

`ifdef BAGMAN_ROM_CHECKSUM_EN
  localparam logic [15:0] SUM_EXP = 16'h0088;
  localparam logic [15:0] SUM_ALT = 16'h0089;
  localparam logic        OK_ALT  = 1'b0;
`else
  localparam logic [15:0] SUM_EXP = 16'h0000;
  localparam logic [15:0] SUM_ALT = 16'h0000;
  localparam logic        OK_ALT  = 1'b1;
`endif

  bagman_rom_loader #(
    .ROM_BYTES(16),
    .HOLD_CYCLES(16),
    .EXPECTED_SUM(16'h0088)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .dn_addr(dn_addr),
    .dn_data(dn_data),
    .dn_wr(dn_wr),
    .core_reset(core_reset),
    .rom_ok(rom_ok),
    .overrun(overrun),
    .rom_sum(rom_sum)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin : monitor
    exp_t e;
    if (dn_wr) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL dn_wr_unexpected: got addr=%0h data=%0h, want no write",
                 dn_addr, dn_data);
      end else begin
        e = sbq.pop_front();
        if (dn_addr !== e.a || dn_data !== e.d || cyc != e.c) begin
          bad++;
          $display("FAIL dn_write: got addr=%0h data=%0h cyc=%0d, want addr=%0h data=%0h cyc=%0d",
                   dn_addr, dn_data, cyc, e.a, e.d, e.c);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d,
                         input bit push);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (push) sbq.push_back('{a[16:0], d, cyc + 1});
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) wr_byte(25'(i), 8'(i + 1), 1'b1);
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic release_dl(input string name);
    ioctl_download = 1'b0;
    tick();
    tick(15);
    chk({name, "_hold15"}, core_reset, 1);
    tick();
    chk({name, "_run"}, core_reset, 0);
  endtask

  initial begin
    tick(2);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_dn_wr", dn_wr, 0);
    chk("rst_dn_addr", dn_addr, 0);
    chk("rst_rom_ok", rom_ok, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_rom_sum", rom_sum, 0);
    reset_n = 1'b1;
    tick(3);
    chk("idle_core_reset", core_reset, 1);

    start_dl();
    stream(16);
    release_dl("full");
    chk("full_rom_ok", rom_ok, 1);
    chk("full_overrun", overrun, 0);
    chk("full_rom_sum", rom_sum, SUM_EXP);
    chk("full_drain", sbq.size(), 0);

    start_dl();
    chk("rerun_core_reset", core_reset, 1);
    chk("rerun_rom_ok_clr", rom_ok, 0);
    stream(16);
    wr_byte(25'd16, 8'hAA, 1'b0);
    chk("ovr_set", overrun, 1);
    release_dl("ovr");
    chk("ovr_rom_ok", rom_ok, 0);
    chk("ovr_sticky", overrun, 1);
    chk("ovr_drain", sbq.size(), 0);

    start_dl();
    chk("short_ovr_clr", overrun, 0);
    stream(12);
    release_dl("short");
    chk("short_rom_ok", rom_ok, 0);
    chk("short_drain", sbq.size(), 0);

    start_dl();
    stream(16);
    ioctl_download = 1'b0;
    tick();
    tick(4);
    chk("hold5_core_reset", core_reset, 1);
    ioctl_download = 1'b1;
    tick();
    chk("hold_reenter_core_reset", core_reset, 1);
    tick(20);
    chk("hold_reenter_stays", core_reset, 1);
    stream(12);
    release_dl("reenter");
    chk("reenter_cnt_clr", rom_ok, 0);
    chk("reenter_drain", sbq.size(), 0);

    start_dl();
    stream(8);
    tick();
    chk("mid_dn_addr", dn_addr, 7);
    reset_n    = 1'b0;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'd8;
    ioctl_dout = 8'h09;
    #1;
    chk("arst_dn_wr", dn_wr, 0);
    chk("arst_dn_addr", dn_addr, 0);
    chk("arst_dn_data", dn_data, 0);
    chk("arst_core_reset", core_reset, 1);
    chk("arst_overrun", overrun, 0);
    chk("arst_rom_sum", rom_sum, 0);
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(30);
    chk("arst_idle_core_reset", core_reset, 1);
    chk("arst_idle_rom_ok", rom_ok, 0);
    chk("arst_drain", sbq.size(), 0);

    start_dl();
    stream(16);
    release_dl("sum");
    chk("sum_value", rom_sum, SUM_EXP);
    chk("sum_rom_ok", rom_ok, 1);

    start_dl();
    wr_byte(25'd0, 8'h02, 1'b1);
    for (int i = 1; i < 16; i++) wr_byte(25'(i), 8'(i + 1), 1'b1);
    release_dl("alt");
    chk("alt_sum", rom_sum, SUM_ALT);
    chk("alt_rom_ok", rom_ok, OK_ALT);
    chk("alt_drain", sbq.size(), 0);

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
